// File: rtl/fsm_seq_pkg.sv
// rtl/fsm_seq_pkg.sv - shared codes, state/mode encodings and path tables for the sequence driver
package fsm_seq_pkg;

   // Peer FSM codes as reported on {o1,o2,err}
   localparam logic [2:0] CODE_IDLE = 3'b000;
   localparam logic [2:0] CODE_S1   = 3'b100;
   localparam logic [2:0] CODE_S2   = 3'b010;
   localparam logic [2:0] CODE_ERR  = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_STEP,
      ST_WAIT,
      ST_RECOVER,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      MODE_FULL_LOOP  = 2'd0,
      MODE_ERR_BOUNCE = 2'd1,
      MODE_S1_ERR     = 2'd2,
      MODE_S2_ERR     = 2'd3
   } mode_t;

   // Number of steps in each predefined path
   function automatic logic [2:0] path_len(input mode_t m);
      case (m)
         MODE_FULL_LOOP:  path_len = 3'd3;
         MODE_ERR_BOUNCE: path_len = 3'd2;
         MODE_S1_ERR:     path_len = 3'd3;
         MODE_S2_ERR:     path_len = 3'd4;
         default:         path_len = 3'd1;
      endcase
   endfunction

   // Vector that walks the peer one state closer to IDLE from the observed code
   function automatic logic [1:0] recover_vec(input logic [2:0] code);
      case (code)
         CODE_S1: recover_vec = 2'b01;
         CODE_S2: recover_vec = 2'b10;
         default: recover_vec = 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/fsm_seq_driver_if.sv
// rtl/fsm_seq_driver_if.sv - handshake between the sequence driver and the peer FSM
interface fsm_seq_driver_if;
   logic i1;
   logic i2;
   logic o1;
   logic o2;
   logic err;

   modport master (output i1, output i2, input o1, input o2, input err);
   modport slave  (input i1, input i2, output o1, output o2, output err);
endinterface

// File: rtl/fsm_seq_step_rom.sv
// rtl/fsm_seq_step_rom.sv - (mode, step) to step vector, expected code, stay vector and last flag
module fsm_seq_step_rom
   import fsm_seq_pkg::*;
(
   input  mode_t      mode,
   input  logic [1:0] step,
   output logic [1:0] step_vec,
   output logic [2:0] exp_code,
   output logic [1:0] stay_vec,
   output logic       last
);

   // Path table lookup plus the vector that holds the peer in its expected state
   always_comb begin
      step_vec = 2'b00;
      exp_code = CODE_IDLE;
      case (mode)
         MODE_FULL_LOOP: begin
            case (step)
               2'd0:    begin step_vec = 2'b11; exp_code = CODE_S1;   end
               2'd1:    begin step_vec = 2'b11; exp_code = CODE_S2;   end
               default: begin step_vec = 2'b10; exp_code = CODE_IDLE; end
            endcase
         end
         MODE_ERR_BOUNCE: begin
            case (step)
               2'd0:    begin step_vec = 2'b10; exp_code = CODE_ERR;  end
               default: begin step_vec = 2'b00; exp_code = CODE_IDLE; end
            endcase
         end
         MODE_S1_ERR: begin
            case (step)
               2'd0:    begin step_vec = 2'b11; exp_code = CODE_S1;   end
               2'd1:    begin step_vec = 2'b01; exp_code = CODE_ERR;  end
               default: begin step_vec = 2'b00; exp_code = CODE_IDLE; end
            endcase
         end
         default: begin
            case (step)
               2'd0:    begin step_vec = 2'b11; exp_code = CODE_S1;   end
               2'd1:    begin step_vec = 2'b11; exp_code = CODE_S2;   end
               2'd2:    begin step_vec = 2'b00; exp_code = CODE_ERR;  end
               default: begin step_vec = 2'b00; exp_code = CODE_IDLE; end
            endcase
         end
      endcase

      case (exp_code)
         CODE_S2:  stay_vec = 2'b01;
         CODE_ERR: stay_vec = 2'b10;
         default:  stay_vec = 2'b00;
      endcase

      last = ({1'b0, step} == (path_len(mode) - 3'd1));
   end

endmodule

// File: rtl/fsm_seq_driver.sv
// rtl/fsm_seq_driver.sv - stimulus driver and checker for the i1/i2 handshake FSM; FSM_SEQ_DRIVER_STATS_EN adds run counters
module fsm_seq_driver
   import fsm_seq_pkg::*;
#(
   parameter int DWELL       = 1,
   parameter int RECOVER_MAX = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] mode,
   fsm_seq_driver_if.master peer,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [1:0] fail_step,
   output logic [2:0] fail_code,
   output logic       abort
`ifdef FSM_SEQ_DRIVER_STATS_EN
   ,
   output logic [15:0] run_cnt,
   output logic [15:0] pass_cnt,
   output logic [15:0] abort_cnt
`endif
);

   localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
   localparam logic [7:0] REC_LAST   = 8'(RECOVER_MAX - 1);

   state_t     state_q, state_d;
   mode_t      mode_q, mode_d;
   logic [1:0] step_q, step_d;
   logic [7:0] dwell_q, dwell_d;
   logic [7:0] rec_q, rec_d;
   logic [2:0] exp_q, exp_d;
   logic       last_q, last_d;
   logic [1:0] i_q, i_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;
   logic [1:0] fail_step_q, fail_step_d;
   logic [2:0] fail_code_q, fail_code_d;
   logic       abort_q, abort_d;

   logic [2:0] obs;
   logic [1:0] rom_step_vec;
   logic [2:0] rom_exp;
   logic [1:0] rom_stay_vec;
   logic       rom_last;

   assign obs = {peer.o1, peer.o2, peer.err};

   // Looked up for the step the FSM is about to enter, so outputs stay registered
   fsm_seq_step_rom u_rom (
      .mode     (mode_d),
      .step     (step_d),
      .step_vec (rom_step_vec),
      .exp_code (rom_exp),
      .stay_vec (rom_stay_vec),
      .last     (rom_last)
   );

   // Next-state and next-output computation for the step/compare/recover sequence
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      step_d      = step_q;
      dwell_d     = dwell_q;
      rec_d       = rec_q;
      exp_d       = exp_q;
      last_d      = last_q;
      pass_d      = pass_q;
      fail_step_d = fail_step_q;
      fail_code_d = fail_code_q;
      abort_d     = abort_q;
      i_d         = 2'b00;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mode_d      = mode_t'(mode);
               step_d      = 2'd0;
               pass_d      = 1'b0;
               fail_step_d = 2'd0;
               fail_code_d = CODE_IDLE;
               abort_d     = 1'b0;
               state_d     = ST_STEP;
            end
         end
         ST_STEP: begin
            dwell_d = 8'd0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (dwell_q == DWELL_LAST) begin
               if (obs == exp_q) begin
                  if (last_q) begin
                     pass_d  = 1'b1;
                     state_d = ST_DONE;
                  end else begin
                     step_d  = step_q + 2'd1;
                     state_d = ST_STEP;
                  end
               end else begin
                  fail_step_d = step_q;
                  fail_code_d = obs;
                  pass_d      = 1'b0;
                  rec_d       = 8'd0;
                  state_d     = ST_RECOVER;
               end
            end else begin
               dwell_d = dwell_q + 8'd1;
            end
         end
         ST_RECOVER: begin
            if (obs == CODE_IDLE) begin
               state_d = ST_DONE;
            end else if (rec_q == REC_LAST) begin
               abort_d = 1'b1;
               state_d = ST_DONE;
            end else begin
               rec_d = rec_q + 8'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      case (state_d)
         ST_STEP:    i_d = rom_step_vec;
         ST_WAIT:    i_d = rom_stay_vec;
         ST_RECOVER: i_d = recover_vec(obs);
         default:    i_d = 2'b00;
      endcase

      if (state_d == ST_STEP) begin
         exp_d  = rom_exp;
         last_d = rom_last;
      end

      busy_d = (state_d == ST_STEP) || (state_d == ST_WAIT) || (state_d == ST_RECOVER);
      done_d = (state_d == ST_DONE);
   end

   // State and registered outputs; reset also kills any run without a done pulse
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_FULL_LOOP;
         step_q      <= 2'd0;
         dwell_q     <= 8'd0;
         rec_q       <= 8'd0;
         exp_q       <= CODE_IDLE;
         last_q      <= 1'b0;
         i_q         <= 2'b00;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_step_q <= 2'd0;
         fail_code_q <= CODE_IDLE;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         step_q      <= step_d;
         dwell_q     <= dwell_d;
         rec_q       <= rec_d;
         exp_q       <= exp_d;
         last_q      <= last_d;
         i_q         <= i_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         fail_step_q <= fail_step_d;
         fail_code_q <= fail_code_d;
         abort_q     <= abort_d;
      end
   end

   assign peer.i1   = i_q[1];
   assign peer.i2   = i_q[0];
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_step = fail_step_q;
   assign fail_code = fail_code_q;
   assign abort     = abort_q;

`ifdef FSM_SEQ_DRIVER_STATS_EN
   logic [15:0] run_cnt_q, run_cnt_d;
   logic [15:0] pass_cnt_q, pass_cnt_d;
   logic [15:0] abort_cnt_q, abort_cnt_d;

   // Saturating counters bumped together with the done pulse
   always_comb begin
      run_cnt_d   = run_cnt_q;
      pass_cnt_d  = pass_cnt_q;
      abort_cnt_d = abort_cnt_q;
      if (done_d) begin
         if (run_cnt_q != 16'hFFFF)                run_cnt_d   = run_cnt_q + 16'd1;
         if (pass_d && (pass_cnt_q != 16'hFFFF))   pass_cnt_d  = pass_cnt_q + 16'd1;
         if (abort_d && (abort_cnt_q != 16'hFFFF)) abort_cnt_d = abort_cnt_q + 16'd1;
      end
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         run_cnt_q   <= 16'd0;
         pass_cnt_q  <= 16'd0;
         abort_cnt_q <= 16'd0;
      end else begin
         run_cnt_q   <= run_cnt_d;
         pass_cnt_q  <= pass_cnt_d;
         abort_cnt_q <= abort_cnt_d;
      end
   end

   assign run_cnt   = run_cnt_q;
   assign pass_cnt  = pass_cnt_q;
   assign abort_cnt = abort_cnt_q;
`endif

endmodule

// File: tb/tb_fsm_seq_driver.sv
// tb/tb_fsm_seq_driver.sv - directed-vector bench for fsm_seq_driver with a peer FSM model
module tb_fsm_seq_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [1:0] mode = 2'd0;
   logic       busy, done, pass, abort;
   logic [1:0] fail_step;
   logic [2:0] fail_code;
`ifdef FSM_SEQ_DRIVER_STATS_EN
   logic [15:0] run_cnt, pass_cnt, abort_cnt;
`endif

   int total = 0;
   int bad = 0;

   logic [2:0] m_state;
   logic [2:0] rep;
   logic       force_s2_zero = 1'b0;
   logic       stuck_s1 = 1'b0;

   logic [1:0] trace [0:63];
   logic       busy_tr [0:63];
   int         done_c;

   fsm_seq_driver_if pif ();

   fsm_seq_driver #(.DWELL(1), .RECOVER_MAX(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode      (mode),
      .peer      (pif),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .fail_step (fail_step),
      .fail_code (fail_code),
      .abort     (abort)
`ifdef FSM_SEQ_DRIVER_STATS_EN
      ,
      .run_cnt   (run_cnt),
      .pass_cnt  (pass_cnt),
      .abort_cnt (abort_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Peer FSM model with registered code output
   always @(posedge clk) begin
      if (!rst) begin
         m_state <= 3'b000;
      end else begin
         case (m_state)
            3'b000: if ({pif.i1, pif.i2} == 2'b11) m_state <= 3'b100;
                    else if ({pif.i1, pif.i2} == 2'b10) m_state <= 3'b111;
            3'b100: if ({pif.i1, pif.i2} == 2'b11) m_state <= 3'b010;
                    else if ({pif.i1, pif.i2} == 2'b01) m_state <= 3'b111;
            3'b010: if ({pif.i1, pif.i2} == 2'b10) m_state <= 3'b000;
                    else if ({pif.i1, pif.i2} == 2'b00) m_state <= 3'b111;
            default: if (pif.i1 == 1'b0) m_state <= 3'b000;
         endcase
      end
   end

   assign rep = stuck_s1 ? 3'b100 :
                (force_s2_zero && (m_state == 3'b010)) ? 3'b000 : m_state;
   assign pif.o1  = rep[2];
   assign pif.o2  = rep[1];
   assign pif.err = rep[0];

   task automatic do_reset();
      rst = 1'b0;
      start = 1'b0;
      force_s2_zero = 1'b0;
      stuck_s1 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // Launch a run, scramble mode after acceptance, record i1i2/busy per cycle until done
   task automatic run_mode(input logic [1:0] m);
      @(negedge clk);
      start = 1'b1;
      mode = m;
      @(negedge clk);
      start = 1'b0;
      mode = m + 2'd1;
      done_c = -1;
      for (int c = 1; c < 60; c++) begin
         trace[c] = {pif.i1, pif.i2};
         busy_tr[c] = busy;
         if (done === 1'b1) begin
            done_c = c;
            break;
         end
         @(negedge clk);
      end
      total++;
      if (done_c < 0) begin
         bad++;
         $display("FAIL done_timeout mode=%0d: no done within 60 cycles", m);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({pif.i1, pif.i2, busy, done, pass, abort, fail_step, fail_code} !== 11'd0) begin
         bad++;
         $display("FAIL reset_outputs got=%b want=%b",
                  {pif.i1, pif.i2, busy, done, pass, abort, fail_step, fail_code}, 11'd0);
      end
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({pif.i1, pif.i2, busy, done} !== 4'b0000) begin
         bad++;
         $display("FAIL idle_after_reset got=%b want=0000", {pif.i1, pif.i2, busy, done});
      end
   endtask

   task automatic test_mode0();
      logic [11:0] got;
      logic [11:0] want;
      want = 12'b11_00_11_01_10_00;
      do_reset();
      run_mode(2'd0);
      got = '0;
      for (int c = 1; c <= 6; c++) got = {got[9:0], trace[c]};
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL mode0_i1i2_seq got=%b want=%b", got, want);
      end
      total++;
      if (done_c + 1 != 8) begin
         bad++;
         $display("FAIL mode0_latency got=%0d want=8", done_c + 1);
      end
      total++;
      if ({pass, abort} !== 2'b10) begin
         bad++;
         $display("FAIL mode0_pass_abort got=%b want=10", {pass, abort});
      end
      total++;
      if ({busy_tr[1], busy_tr[2], busy_tr[3], busy_tr[4], busy_tr[5], busy_tr[6]} !== 6'b111111) begin
         bad++;
         $display("FAIL mode0_busy got=%b want=111111",
                  {busy_tr[1], busy_tr[2], busy_tr[3], busy_tr[4], busy_tr[5], busy_tr[6]});
      end
      @(negedge clk);
      total++;
      if ({busy, done, pass} !== 3'b001) begin
         bad++;
         $display("FAIL mode0_after_done got=%b want=001", {busy, done, pass});
      end
   endtask

   task automatic test_modes123();
      int lens [0:3];
      lens = '{3, 2, 3, 4};
      for (int m = 1; m <= 3; m++) begin
         do_reset();
         run_mode(2'(m));
         total++;
         if (done_c != 2 * lens[m] + 1) begin
            bad++;
            $display("FAIL mode%0d_latency got=%0d want=%0d", m, done_c + 1, 2 * lens[m] + 2);
         end
         total++;
         if ({pass, abort} !== 2'b10) begin
            bad++;
            $display("FAIL mode%0d_pass_abort got=%b want=10", m, {pass, abort});
         end
         total++;
         if (rep !== 3'b000) begin
            bad++;
            $display("FAIL mode%0d_peer_end got=%b want=000", m, rep);
         end
      end
   endtask

   task automatic test_mismatch();
      do_reset();
      force_s2_zero = 1'b1;
      run_mode(2'd0);
      total++;
      if ({pass, abort, fail_step, fail_code} !== 7'b0_0_01_000) begin
         bad++;
         $display("FAIL mismatch_capture got=%b want=%b", {pass, abort, fail_step, fail_code}, 7'b0_0_01_000);
      end
      total++;
      if (done_c != 6) begin
         bad++;
         $display("FAIL mismatch_done_cycle got=%0d want=6", done_c);
      end
   endtask

   task automatic test_stuck_abort();
      int n01;
      do_reset();
      stuck_s1 = 1'b1;
      run_mode(2'd0);
      n01 = 0;
      if (done_c > 12) for (int c = 5; c <= 12; c++) if (trace[c] == 2'b01) n01++;
      total++;
      if (n01 != 8) begin
         bad++;
         $display("FAIL stuck_recover_01_cycles got=%0d want=8", n01);
      end
      total++;
      if (done_c != 13) begin
         bad++;
         $display("FAIL stuck_done_cycle got=%0d want=13", done_c);
      end
      total++;
      if ({pass, abort, fail_step, fail_code} !== 7'b0_1_01_100) begin
         bad++;
         $display("FAIL stuck_abort_capture got=%b want=%b", {pass, abort, fail_step, fail_code}, 7'b0_1_01_100);
      end
      n01 = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done === 1'b1) n01++;
      end
      total++;
      if (n01 != 0 || abort !== 1'b1) begin
         bad++;
         $display("FAIL stuck_single_done extra_done=%0d abort=%b want 0 and 1", n01, abort);
      end
      stuck_s1 = 1'b0;
   endtask

   task automatic test_back_to_back();
      int ndone;
      do_reset();
      @(negedge clk);
      start = 1'b1;
      mode = 2'd0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      total++;
      if ({pif.i1, pif.i2, busy} !== 3'b011) begin
         bad++;
         $display("FAIL busy_start_ignored got=%b want=011", {pif.i1, pif.i2, busy});
      end
      @(negedge clk);
      total++;
      if ({pif.i1, pif.i2} !== 2'b10) begin
         bad++;
         $display("FAIL step2_vector got=%b want=10", {pif.i1, pif.i2});
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({pif.i1, pif.i2, busy, done, pass, abort, fail_step, fail_code} !== 11'd0) begin
         bad++;
         $display("FAIL midrun_reset_outputs got=%b want=%b",
                  {pif.i1, pif.i2, busy, done, pass, abort, fail_step, fail_code}, 11'd0);
      end
      rst = 1'b1;
      ndone = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) ndone++;
      end
      total++;
      if (ndone != 0) begin
         bad++;
         $display("FAIL midrun_reset_no_done got=%0d want=0", ndone);
      end
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_modes123();
      test_mismatch();
      test_stuck_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
